// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with an optional second (skid) entry, flush-to-bubble
// and a saturating count of downstream back-pressure cycles.
module pipe_stage_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] stall_q;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state != EMPTY) && !flush;
  assign out_data  = main_q;
  assign occupancy = 2'(state);
  assign stall_cnt = stall_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // The skid variant decouples in_ready from out_ready; the single-entry variant
  // accepts into a full stage only when the held payload leaves the same cycle.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state != TWO) && !flush && !rst;
    end else begin : g_single
      assign in_ready = ((state == EMPTY) || out_ready) && !flush && !rst;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      // Flush empties the stage but leaves the data registers as they were.
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_xfer) begin
              state  <= ONE;
              main_q <= in_data;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_q <= in_data;
            end else if (in_xfer && (SKID != 0)) begin
              state  <= TWO;
              skid_q <= in_data;
            end else if (out_xfer) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (out_xfer) begin
              state  <= ONE;
              main_q <= skid_q;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter SKID, default 1; 0 selects single-entry stage, 1 selects two-entry skid stage.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port flush  input  1  discard all held payloads (bubble insertion).
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-011 SHALL have port out_ready  input  1  downstream accepts payload.
REQ-012 SHALL have port out_data  output  WIDTH  oldest held payload.
REQ-013 SHALL have port occupancy  output  2  number of held payloads (0..2).
REQ-014 SHALL have port stall_cnt  output  CNT_W  count of downstream back-pressure cycles.

Function
REQ-015 SHALL define input transfer as in_valid && in_ready; output transfer as out_valid && out_ready.
REQ-016 SHALL hold state EMPTY, ONE or (SKID=1 only) TWO; occupancy = 0/1/2 respectively.
REQ-017 SHALL drive out_valid = (state != EMPTY) && !flush; out_data = main entry register.
REQ-018 SHALL, for SKID=1, drive in_ready = (state != TWO) && !flush && !rst, registered-state only (no combinational path from out_ready).
REQ-019 SHALL, for SKID=0, drive in_ready = (state == EMPTY || out_ready) && !flush && !rst.
REQ-020 SHALL transition EMPTY: input transfer -> ONE, main <= in_data; else stay.
REQ-021 SHALL transition ONE: in+out transfer -> ONE, main <= in_data; in only -> TWO (SKID=1), skid <= in_data; out only -> EMPTY; neither -> stay.
REQ-022 SHALL transition TWO: out transfer -> ONE, main <= skid; else stay, both entries held unchanged.
REQ-023 SHALL deliver payloads in strict arrival order, with latency of exactly one cycle from input transfer to out_valid when the stage was EMPTY.
REQ-024 SHALL never drop or duplicate a payload outside flush and rst.
REQ-025 SHALL on flush=1 force next state EMPTY, regardless of in_valid/out_ready; no transfers occur that cycle; data registers keep contents.
REQ-026 SHALL increment stall_cnt each cycle out_valid && !out_ready, saturating at 2^CNT_W-1; flush does not clear it.
REQ-027 SHALL hold out_data stable while out_valid && !out_ready.

Reset
REQ-028 SHALL on rst=1 at a clock edge set state EMPTY, main and skid to 0, stall_cnt to 0; rst overrides flush and all handshakes.
REQ-029 SHALL while rst=1 drive in_ready=0, out_valid=0, occupancy=0, out_data=0 from the following edge on.
REQ-030 SHALL discard held payloads on rst asserted mid-operation; first post-reset transfer behaves as from EMPTY.

Verification
REQ-031 SHALL cover: SKID=1, in_data 0xA,0xB,0xC back-to-back, out_ready=1 -> out_data 0xA,0xB,0xC on consecutive cycles, occupancy 1, stall_cnt 0.
REQ-032 SHALL cover: SKID=1, send 0x11,0x22 with out_ready=0 -> occupancy 2, in_ready=0, out_data 0x11; raise out_ready -> 0x11 then 0x22 delivered, in_ready returns 1 after first.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; CNT_W=2, 6 stall cycles -> stall_cnt=3 (saturated).
REQ-034 SHALL cover: state TWO, flush=1 with in_valid=1, out_ready=1 -> no transfer, next cycle occupancy 0, out_valid 0.
REQ-035 SHALL cover: SKID=0, out_ready=0 while ONE -> in_ready=0; out_ready=1 same cycle as in_valid -> simultaneous pass, occupancy stays 1.
REQ-036 SHALL cover: rst during state TWO with stall_cnt=7 -> next cycle occupancy 0, out_data 0, stall_cnt 0, in_ready 0 until rst released.
